// File: rtl/mem_port_arbiter.sv
// Byte-wide external memory port shared by instruction fetch and load/store.
// Sequences multi-byte transfers, round-robin arbitration, fetch flush, IO back-pressure.
module mem_port_arbiter #(
    parameter logic [1:0] IO_PAGE = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr
);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  n_q, n_d;
    logic        last_ls_q, last_ls_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_q, data_d;
    logic        if_done_q, if_done_d;
    logic [31:0] if_data_q, if_data_d;
    logic        ls_done_q, ls_done_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [31:0] mem_a_q, mem_a_d;
    logic        mem_wr_q, mem_wr_d;

    logic        if_ok, grant_ls, io_stall;
    logic [31:0] byte_addr, assembled;
    logic [1:0]  cap_idx;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        last_ls_d  = last_ls_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        data_d     = data_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;
        mem_dout_d = mem_dout_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;

        if_ok     = if_req && !flush;
        grant_ls  = ls_req && (!if_ok || !last_ls_q);
        byte_addr = addr_q + 32'(cnt_q);
        io_stall  = (byte_addr[17:16] == IO_PAGE) && io_buffer_full;
        cap_idx   = cnt_q[1:0] - 2'd1;
        assembled = data_q;
        assembled[8*cap_idx +: 8] = mem_din;

        case (state_q)
            IDLE: begin
                // A done pulse still high means the requester has not yet dropped its request.
                if (!if_done_q && !ls_done_q) begin
                    if (grant_ls) begin
                        addr_d    = ls_addr;
                        wdata_d   = ls_wdata;
                        n_d       = size_bytes(ls_size);
                        data_d    = '0;
                        mem_a_d   = ls_addr;
                        last_ls_d = 1'b1;
                        if (ls_we) begin
                            state_d = LS_WR;
                            if ((ls_addr[17:16] == IO_PAGE) && io_buffer_full) begin
                                cnt_d      = 3'd0;
                                mem_wr_d   = 1'b0;
                                mem_dout_d = '0;
                            end else begin
                                cnt_d      = 3'd1;
                                mem_wr_d   = 1'b1;
                                mem_dout_d = ls_wdata[7:0];
                            end
                        end else begin
                            state_d = LS_RD;
                            cnt_d   = 3'd1;
                        end
                    end else if (if_ok) begin
                        state_d   = IF_RD;
                        addr_d    = if_addr;
                        n_d       = 3'd4;
                        data_d    = '0;
                        mem_a_d   = if_addr;
                        cnt_d     = 3'd1;
                        last_ls_d = 1'b0;
                    end
                end
            end
            IF_RD, LS_RD: begin
                if (state_q == IF_RD && flush) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    mem_a_d = '0;
                end else begin
                    data_d = assembled;
                    if (cnt_q == n_q) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                        mem_a_d = '0;
                        if (state_q == IF_RD) begin
                            if_done_d = 1'b1;
                            if_data_d = assembled;
                        end else begin
                            ls_done_d  = 1'b1;
                            ls_rdata_d = assembled;
                        end
                    end else begin
                        mem_a_d = byte_addr;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end
            LS_WR: begin
                if (cnt_q == n_q) begin
                    state_d    = IDLE;
                    cnt_d      = 3'd0;
                    ls_done_d  = 1'b1;
                    mem_wr_d   = 1'b0;
                    mem_dout_d = '0;
                    mem_a_d    = '0;
                end else if (io_stall) begin
                    mem_wr_d   = 1'b0;
                    mem_dout_d = '0;
                    mem_a_d    = byte_addr;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_a_d    = byte_addr;
                    mem_dout_d = wdata_q[8*cnt_q[1:0] +: 8];
                    cnt_d      = cnt_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; rdy low holds everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            last_ls_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            if_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= '0;
            mem_dout_q <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            last_ls_q  <= last_ls_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
            mem_dout_q <= mem_dout_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
    assign mem_dout = mem_dout_q;
    assign mem_a    = mem_a_q;
    assign mem_wr   = mem_wr_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the single byte-wide external memory port.
- Sequences multi-byte transfers for two requesters: instruction fetch (32-bit reads) and load/store (1/2/4-byte reads and writes).
- Arbitrates between them round-robin.
- Handles pipeline flush for fetch, and back-pressure from the IO output buffer.

Parameters:
- IO_PAGE, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rdy  input  1  global enable; 0 freezes all registers
- flush  input  1  abort any fetch in progress or pending
- io_buffer_full  input  1  IO write buffer cannot accept a byte this cycle
- if_req  input  1  fetch request, held high until if_done
- if_addr  input  32  fetch byte address
- if_done  output  1  one-cycle pulse, if_data valid
- if_data  output  32  fetched word, little-endian
- ls_req  input  1  load/store request, held high until ls_done
- ls_we  input  1  1 = store
- ls_size  input  2  0 = byte, 1 = half, 2 = word (3 treated as word)
- ls_addr  input  32  byte address
- ls_wdata  input  32  store data; low bytes used
- ls_done  output  1  one-cycle pulse
- ls_rdata  output  32  load data, zero-filled above size, no sign extension
- mem_din  input  8  memory read byte
- mem_dout  output  8  memory write byte
- mem_a  output  32  memory address
- mem_wr  output  1  1 = write mem_dout at mem_a

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE, cnt = 0, last_ls = 0 (so a tie on the first arbitration goes to LS).
- rdy = 0: no register changes.
  - The memory itself is gated by the same rdy, so a held mem_wr does not double-write.
- Registered outputs only. Memory read latency is 1: data for the mem_a driven in cycle t appears on mem_din in cycle t+1.
- States:
  - IDLE
  - IF_RD
  - LS_RD
  - LS_WR
- Byte count N is 4 for fetch, 1/2/4 for LS.
- Byte k address is addr + k, with 32-bit wrap. Misalignment is allowed.
- IDLE accept rules:
  - No request is accepted in a cycle where if_done or ls_done is high (this gives a one-cycle bubble so a stale held request is not re-accepted).
  - Otherwise, if both requests are high, grant the one not served last (last_ls). Else grant whichever is high.
  - if_req is ignored while flush = 1.
  - On accept (edge E0):
    - Latch addr, size, we, and wdata.
    - Drive byte 0: mem_a = addr.
    - For a store, also drive mem_wr = 1 and mem_dout = wdata[7:0].
    - Set cnt = 1 and update last_ls.
- Reads (IF_RD / LS_RD):
  - Byte k is driven after edge Ek, for k < N.
  - Byte k is captured from mem_din at edge E(k+1).
  - At edge EN, capture the last byte and assert done with the assembled data; state returns to IDLE.
  - mem_a returns to 0 and mem_wr stays 0 after the last byte is issued.
  - Latency: a word read gives done after E4, i.e. 4 cycles after the accept edge. A byte read gives done after E1.
- Writes (LS_WR):
  - One byte is issued per cycle with mem_wr = 1.
  - If the next byte's address has addr[17:16] == IO_PAGE and io_buffer_full = 1:
    - mem_wr = 0 that cycle and cnt holds.
    - Retry each cycle until the buffer is not full.
  - ls_done is asserted at the edge after the last byte is issued; mem_wr = 0 in that cycle. State goes to IDLE.
- flush:
  - In IF_RD: abort. State goes to IDLE, if_done is not asserted, and partial data is discarded.
  - In LS_RD / LS_WR: no effect. Committed stores and loads always complete.
  - flush in the same cycle as an if_done pulse does not retract that pulse.
- A request arriving while busy is held by the requester and arbitrated at the next eligible IDLE cycle.
- if_data and ls_rdata hold their last values between done pulses.

Test Plan:
- Word fetch: if_req, if_addr = 0x100, memory bytes 0x13,0x05,0x00,0x00 → if_done one cycle, 4 cycles after accept; if_data = 0x00000513; mem_a sequence 0x100..0x103.
- Simultaneous requests from reset: if_req and ls_req (byte load at 0x200) in the same cycle → LS served first, then one-cycle bubble, then IF. Repeat the simultaneous request → order alternates.
- Half store: ls_we = 1, size = 1, addr = 0xFFFFFFFF, wdata = 0xABCD → writes 0xCD @0xFFFFFFFF, 0xAB @0x00000000; ls_done the following cycle.
- IO stall: byte store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for 3 cycles, then one write; ls_done one cycle later.
- Flush mid-fetch: flush after byte 2 of a fetch → no if_done. A following LS request is accepted in the next cycle. A held if_req is re-fetched from byte 0.
- rdy = 0 for 2 cycles mid word load → mem_a/cnt frozen; ls_done delayed by exactly 2 cycles with correct data.
